// File: rtl/hub75_bcm_scheduler_if.sv
// Request/acknowledge handshake between the BCM scheduler (master) and the
// external 64-column shifter (slave).
interface hub75_bcm_scheduler_if;
  logic       shift_req;
  logic [4:0] shift_row;
  logic [2:0] shift_plane;
  logic       shift_done;

  modport master (
    output shift_req,
    output shift_row,
    output shift_plane,
    input  shift_done
  );

  modport slave (
    input  shift_req,
    input  shift_row,
    input  shift_plane,
    output shift_done
  );
endinterface

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 binary-code-modulation scheduler: shifts row/plane data one slot ahead,
// then blanks, latches and displays each plane for BASE_TICKS<<plane cycles.
module hub75_bcm_scheduler #(
  parameter int unsigned ROWS         = 32,
  parameter int unsigned PLANES       = 8,
  parameter int unsigned BASE_TICKS   = 4,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned LAT_CYCLES   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  hub75_bcm_scheduler_if.master shift_if,
  output logic [4:0]            addr,
  output logic                  LAT,
  output logic                  OE,
  output logic                  frame_start
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    WAIT_SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
  localparam logic [2:0]  LAST_PLANE = 3'(PLANES - 1);
  localparam logic [31:0] BLANK_LOAD = 32'(BLANK_CYCLES - 1);
  localparam logic [31:0] LAT_LOAD   = 32'(LAT_CYCLES - 1);
  localparam logic [31:0] BASE       = 32'(BASE_TICKS);

  state_t      r_state;
  logic [4:0]  r_row;
  logic [2:0]  r_plane;
  logic [4:0]  r_shift_row;
  logic [2:0]  r_shift_plane;
  logic        r_shift_req;
  logic        r_outstanding;
  logic        r_ready;
  logic [4:0]  r_addr;
  logic [2:0]  r_lat_plane;
  logic        r_lat;
  logic        r_oe;
  logic        r_frame_start;
  logic [31:0] r_timer;

  logic        w_done_ok;
  logic        w_ready_now;
  logic        w_timer_zero;
  logic [4:0]  w_next_row;
  logic [2:0]  w_next_plane;

  // A done coinciding with its own request pulse is too early to be genuine.
  always_comb begin
    w_done_ok    = shift_if.shift_done & r_outstanding & ~r_shift_req;
    w_ready_now  = r_ready | w_done_ok;
    w_timer_zero = (r_timer == '0);
    w_next_plane = r_plane + 3'd1;
    w_next_row   = r_row;
    if (r_plane == LAST_PLANE) begin
      w_next_plane = '0;
      w_next_row   = (r_row == LAST_ROW) ? '0 : r_row + 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_row         <= '0;
      r_plane       <= '0;
      r_shift_row   <= '0;
      r_shift_plane <= '0;
      r_shift_req   <= 1'b0;
      r_outstanding <= 1'b0;
      r_ready       <= 1'b0;
      r_addr        <= '0;
      r_lat_plane   <= '0;
      r_lat         <= 1'b0;
      r_oe          <= 1'b1;
      r_frame_start <= 1'b0;
      r_timer       <= '0;
    end else begin
      r_shift_req   <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_done_ok) begin
        r_outstanding <= 1'b0;
        r_ready       <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_oe  <= 1'b1;
          r_lat <= 1'b0;
          if (enable) begin
            r_state       <= PRIME;
            r_shift_req   <= 1'b1;
            r_shift_row   <= r_row;
            r_shift_plane <= r_plane;
            r_outstanding <= 1'b1;
          end
        end

        PRIME: r_state <= WAIT_SHIFT;

        WAIT_SHIFT: begin
          if (w_ready_now) begin
            r_state     <= BLANK;
            r_addr      <= r_shift_row;
            r_lat_plane <= r_shift_plane;
            r_ready     <= 1'b0;
            r_timer     <= BLANK_LOAD;
          end
        end

        BLANK: begin
          if (w_timer_zero) begin
            r_state       <= LATCH;
            r_lat         <= 1'b1;
            r_timer       <= LAT_LOAD;
            r_frame_start <= (r_addr == '0) && (r_lat_plane == '0);
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        // Cursor advance and the next shift request land on the first
        // DISPLAY cycle so the shift overlaps the whole display period.
        LATCH: begin
          if (w_timer_zero) begin
            r_state <= DISPLAY;
            r_lat   <= 1'b0;
            r_oe    <= 1'b0;
            r_timer <= (BASE << r_lat_plane) - 32'd1;
            r_row   <= w_next_row;
            r_plane <= w_next_plane;
            if (enable) begin
              r_shift_req   <= 1'b1;
              r_shift_row   <= w_next_row;
              r_shift_plane <= w_next_plane;
              r_outstanding <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        DISPLAY: begin
          if (w_timer_zero) begin
            r_oe <= 1'b1;
            if (w_ready_now) begin
              r_state     <= BLANK;
              r_addr      <= r_shift_row;
              r_lat_plane <= r_shift_plane;
              r_ready     <= 1'b0;
              r_timer     <= BLANK_LOAD;
            end else if (r_outstanding) begin
              r_state <= WAIT_SHIFT;
            end else begin
              r_state <= IDLE;
              r_row   <= '0;
              r_plane <= '0;
            end
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign shift_if.shift_req   = r_shift_req;
  assign shift_if.shift_row   = r_shift_row;
  assign shift_if.shift_plane = r_shift_plane;
  assign addr                 = r_addr;
  assign LAT                  = r_lat;
  assign OE                   = r_oe;
  assign frame_start          = r_frame_start;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Bench for hub75_bcm_scheduler: a latency-configurable shifter model drives the
// handshake while a monitor checks panel timing against the BCM schedule.
module tb_hub75_bcm_scheduler;
  localparam int ROWS   = 4;
  localparam int PLANES = 3;
  localparam int BASE   = 2;
  localparam int BLANK  = 2;
  localparam int LATC   = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [4:0] addr;
  logic       LAT;
  logic       OE;
  logic       frame_start;

  hub75_bcm_scheduler_if sif ();

  hub75_bcm_scheduler #(
    .ROWS(ROWS),
    .PLANES(PLANES),
    .BASE_TICKS(BASE),
    .BLANK_CYCLES(BLANK),
    .LAT_CYCLES(LATC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .shift_if(sif),
    .addr(addr),
    .LAT(LAT),
    .OE(OE),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Shifter model: answers each request shift_lat cycles later.
  int   shift_lat = 1;
  int   done_cnt  = 0;
  logic inject    = 1'b0;

  initial begin
    sif.shift_done = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      sif.shift_done = 1'b0;
      if (reset) begin
        done_cnt = 0;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) sif.shift_done = 1'b1;
        end
        if (sif.shift_req) done_cnt = shift_lat;
      end
      if (inject) sif.shift_done = 1'b1;
    end
  end

  // Reference monitor: the k-th latch/request after a (re)start is slot k of
  // the row-major (row, plane) schedule.
  logic mon_on = 1'b0;
  logic fast   = 1'b0;
  logic forbid = 1'b0;
  int n_req, n_done, n_lat, run_len, gap_len, lat_len, cur_plane, cur_row;
  int cyc, last_fs, fs_total = 0, fs_exp = 0, overlap = 0, bad_req = 0, frame_len;
  logic prev_oe, prev_lat, addr_bad, fs_valid;
  int lat_arr[4096];

  task automatic mon_reset();
    n_req = 0; n_done = 0; n_lat = 0;
    run_len = 0; gap_len = 0; lat_len = 0;
    cur_plane = 0; cur_row = 0; cyc = 0; last_fs = 0;
    prev_oe = 1'b1; prev_lat = 1'b0; addr_bad = 1'b0; fs_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      int d, l, g;
      cyc++;
      if (sif.shift_done && n_done < n_req && !sif.shift_req) n_done++;
      if (sif.shift_req) begin
        if (forbid) bad_req++;
        check_eq("shift_row", int'(sif.shift_row), (n_req / PLANES) % ROWS);
        check_eq("shift_plane", int'(sif.shift_plane), n_req % PLANES);
        lat_arr[n_req & 4095] = shift_lat;
        n_req++;
      end
      if (LAT && !prev_lat) begin
        check_eq("latch_addr", int'(addr), (n_lat / PLANES) % ROWS);
        check_eq("latch_frame_start", int'(frame_start), int'(n_lat % (ROWS * PLANES) == 0));
        check_eq("latch_after_done", int'(n_lat < n_done), 1);
        if (n_lat > 0) begin
          d = BASE << cur_plane;
          l = lat_arr[n_lat & 4095];
          g = BLANK + ((l + 1 > d) ? (l + 1 - d) : 0);
          check_eq("blank_gap", gap_len, g);
        end
        if (n_lat % (ROWS * PLANES) == 0) fs_exp++;
        cur_plane = n_lat % PLANES;
        cur_row   = (n_lat / PLANES) % ROWS;
        n_lat++;
        lat_len = 0;
      end
      if (LAT) lat_len++;
      if (LAT && !OE) overlap++;
      if (frame_start) begin
        fs_total++;
        if (fast && fs_valid) check_eq("frame_period", cyc - last_fs, frame_len);
        last_fs  = cyc;
        fs_valid = 1'b1;
      end
      if (!OE && prev_oe) begin
        check_eq("lat_width", lat_len, LATC);
        check_eq("oe_follows_lat", int'(prev_lat), 1);
        run_len  = 0;
        addr_bad = 1'b0;
      end
      if (!OE) begin
        run_len++;
        if (int'(addr) != cur_row) addr_bad = 1'b1;
      end
      if (OE && !prev_oe) begin
        check_eq("oe_low_run", run_len, BASE << cur_plane);
        check_eq("addr_stable", int'(addr_bad), 0);
        gap_len = 0;
      end
      if (OE && !LAT) gap_len++;
      prev_oe  = OE;
      prev_lat = LAT;
    end
  end

  task automatic watch(input int n, output int oe_low, output int lat_hi, output int reqs);
    oe_low = 0; lat_hi = 0; reqs = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (!OE) oe_low++;
      if (LAT) lat_hi++;
      if (sif.shift_req) reqs++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, oe_low, lat_hi, reqs;
    reset  = 1'b1;
    enable = 1'b0;
    mon_reset();
    frame_len = 0;
    for (int p = 0; p < PLANES; p++) frame_len += (BLANK + LATC + (BASE << p)) * ROWS;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_OE", int'(OE), 1);
    check_eq("rst_LAT", int'(LAT), 0);
    check_eq("rst_addr", int'(addr), 0);
    check_eq("rst_shift_req", int'(sif.shift_req), 0);
    check_eq("rst_shift_row", int'(sif.shift_row), 0);
    check_eq("rst_shift_plane", int'(sif.shift_plane), 0);
    check_eq("rst_frame_start", int'(frame_start), 0);

    // Fast shifter, two full frames with period check.
    reset = 1'b0; mon_reset(); mon_on = 1'b1; fast = 1'b1; enable = 1'b1;
    for (int i = 0; i < 400 && fs_total < 3; i++) begin @(posedge clock); #1; end
    check_eq("two_frames_seen", int'(fs_total >= 3), 1);
    fast = 1'b0;

    // Slow shifter: display waits for shift completion.
    shift_lat = 12;
    target = n_lat + 4;
    for (int i = 0; i < 400 && n_lat < target; i++) begin @(posedge clock); #1; end
    check_eq("slow_progress", int'(n_lat >= target), 1);

    // Random shifter latency.
    target = n_lat + 30;
    for (int i = 0; i < 3000 && n_lat < target; i++) begin
      @(posedge clock);
      #1;
      shift_lat = $urandom_range(20, 1);
    end
    check_eq("random_progress", int'(n_lat >= target), 1);

    // Drop enable in the middle of a plane-2 display.
    shift_lat = 1;
    for (int i = 0; i < 600 && !(!OE && cur_plane == 2 && run_len == 3); i++) begin
      @(posedge clock); #1;
    end
    check_eq("drain_setup", int'(!OE && cur_plane == 2 && run_len == 3), 1);
    enable = 1'b0;
    forbid = 1'b1;
    for (int i = 0; i < 200 && !(n_lat == n_req && OE && !LAT); i++) begin
      @(posedge clock); #1;
    end
    check_eq("drain_complete", int'(n_lat == n_req && OE && !LAT), 1);
    watch(20, oe_low, lat_hi, reqs);
    check_eq("drain_oe_low_cycles", oe_low, 0);
    check_eq("drain_lat_cycles", lat_hi, 0);
    check_eq("drain_requests", bad_req, 0);

    // Spurious done while idle must not create a ready shift.
    inject = 1'b1;
    @(posedge clock); #1;
    inject = 1'b0;
    watch(10, oe_low, lat_hi, reqs);
    check_eq("spurious_oe_low", oe_low, 0);
    check_eq("spurious_lat", lat_hi, 0);
    check_eq("spurious_req", reqs, 0);

    // Re-enable: restart at row 0 / plane 0.
    mon_reset(); forbid = 1'b0; shift_lat = 5; enable = 1'b1;
    for (int i = 0; i < 300 && n_lat < 4; i++) begin @(posedge clock); #1; end
    check_eq("restart_progress", int'(n_lat >= 4), 1);

    // Reset while latching a non-zero row.
    shift_lat = 2;
    for (int i = 0; i < 300 && !(LAT && addr != 5'd0); i++) begin @(posedge clock); #1; end
    check_eq("reset_setup", int'(LAT && addr != 5'd0), 1);
    reset = 1'b1; mon_on = 1'b0; enable = 1'b0;
    @(posedge clock); #1;
    check_eq("midrst_LAT", int'(LAT), 0);
    check_eq("midrst_OE", int'(OE), 1);
    check_eq("midrst_addr", int'(addr), 0);
    check_eq("midrst_shift_req", int'(sif.shift_req), 0);
    check_eq("midrst_frame_start", int'(frame_start), 0);
    @(posedge clock); #1;
    reset = 1'b0; mon_reset(); mon_on = 1'b1;
    inject = 1'b1;
    @(posedge clock); #1;
    inject = 1'b0;
    watch(10, oe_low, lat_hi, reqs);
    check_eq("stale_oe_low", oe_low, 0);
    check_eq("stale_lat", lat_hi, 0);
    check_eq("stale_req", n_req, 0);

    shift_lat = 3; enable = 1'b1;
    for (int i = 0; i < 300 && n_lat < 2 * PLANES; i++) begin @(posedge clock); #1; end
    check_eq("post_reset_progress", int'(n_lat >= 2 * PLANES), 1);

    check_eq("frame_start_count", fs_total, fs_exp);
    check_eq("lat_oe_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_scheduler.md
Name: hub75_bcm_scheduler

Overview:
- Sequences the HUB75 panel datapath using binary-code modulation (BCM).
- For each row address and each bit-plane it:
  - requests a 64-pixel shift from the external column shifter;
  - blanks the panel, drives the row address and pulses LAT;
  - holds OE active for a time weighted by 2^plane.
- The shift for the next (row, plane) overlaps the current display period.
- Sits between the framebuffer/shifter block and the panel pins; it owns A–E (as addr), LAT and OE.

Parameters:
- ROWS, 32, number of scanned row addresses (max 32, addr is 5 bits).
- PLANES, 8, bit-planes per colour (1..8).
- BASE_TICKS, 4, display cycles for plane 0; plane p displays BASE_TICKS<<p cycles.
- BLANK_CYCLES, 2, OE-high cycles before each latch (ghosting guard), >=1.
- LAT_CYCLES, 1, LAT-high cycles per latch, >=1.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  scan enable; sampled every cycle.
- shift_req  out  1  one-cycle pulse: shifter loads and shifts row shift_row, plane shift_plane.
- shift_row  out  5  row index for the requested shift; stable from shift_req until shift_done.
- shift_plane  out  3  plane index for the requested shift; stable from shift_req until shift_done.
- shift_done  in  1  one-cycle pulse from the shifter: 64 columns shifted, CLK idle low.
- addr  out  5  panel row address {E,D,C,B,A}.
- LAT  out  1  panel latch, active-high.
- OE  out  1  panel output enable, active-low (1 = blanked).
- frame_start  out  1  one-cycle pulse when row 0 / plane 0 is latched.

Behaviour:
- Reset values: OE=1, LAT=0, addr=0, shift_req=0, shift_row=0, shift_plane=0, frame_start=0; state IDLE; cursor (row, plane)=(0,0); outstanding=0, ready=0.
- States: IDLE, PRIME, WAIT_SHIFT, BLANK, LATCH, DISPLAY.
- IDLE:
  - OE=1.
  - If enable: go to PRIME.
- PRIME:
  - shift_req=1 for one cycle with the cursor (0,0); set outstanding=1.
  - Go to WAIT_SHIFT.
- WAIT_SHIFT:
  - OE=1.
  - When ready=1, or shift_done is seen while outstanding, go to BLANK next cycle.
- BLANK:
  - OE=1 for BLANK_CYCLES cycles.
  - addr takes the pending row on the first BLANK cycle.
  - Clear ready.
- LATCH:
  - LAT=1 for LAT_CYCLES cycles; OE stays 1.
  - frame_start=1 on the first LATCH cycle when the pending (row, plane)=(0,0).
- DISPLAY:
  - OE=0; timer loads BASE_TICKS<<plane and OE stays low exactly that many cycles. Timer is 32 bits wide.
  - First DISPLAY cycle: advance the cursor (plane+1; on wrap from PLANES-1, plane=0 and row+1; row wraps ROWS-1 -> 0).
  - If enable, pulse shift_req with the new cursor and set outstanding=1.
- shift_done handling:
  - shift_done while outstanding clears outstanding and sets ready.
  - shift_done while not outstanding is ignored.
  - shift_done in the same cycle as shift_req is not counted; done must be at least one cycle later.
- Display end:
  - If ready: BLANK.
  - Else if outstanding: WAIT_SHIFT, with OE=1 while waiting.
  - Else (enable was low, no request issued): IDLE.
- Disable drain: enable low never truncates an active DISPLAY, never aborts an outstanding shift, and never issues a new shift_req. After the drain completes the block enters IDLE with OE=1 and cursor reset to (0,0).
- Reset mid-operation: all outputs return to reset values on the next edge. Any in-flight shift_done after reset is ignored.
- Steady-state period per plane (shifter faster than display) = BLANK_CYCLES + LAT_CYCLES + (BASE_TICKS<<p).
- LAT and OE=0 are never high/low simultaneously; addr never changes while OE=0.

Test Plan:
- Reset then enable=1; ROWS=4, PLANES=3, BASE_TICKS=2, BLANK=2, LAT=1; shifter model answers shift_done 1 cycle after shift_req -> OE-low runs of exactly 2,4,8 cycles separated by 3 OE-high cycles. Each OE-high gap contains 2 blank cycles followed by a 1-cycle LAT pulse.
- Same config, run 2 frames -> addr sequence 0,0,0,1,1,1,2,2,2,3,3,3,0…; shift_plane cycles 0,1,2; frame_start pulses every 92 cycles.
- Shifter latency 12 cycles -> after plane-0 display (2 cycles) OE stays high in WAIT_SHIFT. LAT is not asserted until shift_done is seen. The following OE-low run is still exactly 4 cycles.
- Drop enable mid plane-2 display -> OE-low run completes its full 8 cycles. No further shift_req is issued; OE=1 thereafter; state IDLE. Re-enable -> first latch is row 0 / plane 0 with a frame_start pulse.
- Inject spurious shift_done while nothing is outstanding -> no state change and no early latch.
- Assert reset during LATCH with LAT=1 -> next cycle LAT=0, OE=1, addr=0, shift_req=0. A stale shift_done arriving afterwards is ignored.
